// File: rtl/qsram_ctrl_pkg.sv
// Shared types for the quasi-static SRAM sequencer: FSM states and the
// strobe selector that drives the array's edge lines.
`timescale 1ns/1ps
package qsram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    REFRESH,
    RECOVER
  } qsram_state_t;

  typedef enum logic [1:0] {
    STROBE_NONE,
    STROBE_READ,
    STROBE_WRITE,
    STROBE_REFRESH
  } strobe_sel_t;

  // Returns {ReadEdge, WriteEdge, RefreshEdge}; one-hot by construction.
  function automatic logic [2:0] strobeDecode(input strobe_sel_t sel);
    case (sel)
      STROBE_READ:    return 3'b100;
      STROBE_WRITE:   return 3'b010;
      STROBE_REFRESH: return 3'b001;
      default:        return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/qsram_refresh_timer.sv
// Free-running refresh interval timer with pending/defer bookkeeping,
// the sweep row pointer and the sticky overrun flag.
`timescale 1ns/1ps
module qsram_refresh_timer #(
  parameter int ROWS             = 16,
  parameter int ADDR_W           = $clog2(ROWS),
  parameter int REFRESH_INTERVAL = 64,
  parameter int MAX_DEFER        = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              RefreshStart,
  input  logic              RefreshDone,
  input  logic              AccessAccepted,
  output logic              Pending,
  output logic              DeferSaturated,
  output logic [ADDR_W-1:0] RefPtr,
  output logic              RefreshOverrun
);

  localparam int CNT_W   = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam int DEFER_W = $clog2(MAX_DEFER + 1);
  localparam logic [CNT_W-1:0]   RELOAD    = CNT_W'(REFRESH_INTERVAL - 1);
  localparam logic [DEFER_W-1:0] DEFER_MAX = DEFER_W'(MAX_DEFER);
  localparam logic [ADDR_W-1:0]  LAST_ROW  = ADDR_W'(ROWS - 1);

  logic [CNT_W-1:0]   counter;
  logic [DEFER_W-1:0] deferCnt;

  assign DeferSaturated = (deferCnt == DEFER_MAX);

  always_ff @(posedge Clock) begin
    if (Reset) begin
      counter        <= RELOAD;
      Pending        <= 1'b0;
      RefreshOverrun <= 1'b0;
      RefPtr         <= '0;
      deferCnt       <= '0;
    end else begin
      counter <= (counter == '0) ? RELOAD : counter - 1'b1;

      // A new expiry outranks a completing refresh so no request is lost.
      if (counter == '0) begin
        Pending <= 1'b1;
        if (Pending) RefreshOverrun <= 1'b1;
      end else if (RefreshDone) begin
        Pending <= 1'b0;
      end

      if (RefreshDone) RefPtr <= (RefPtr == LAST_ROW) ? '0 : RefPtr + 1'b1;

      if (RefreshStart) deferCnt <= '0;
      else if (AccessAccepted && Pending && !DeferSaturated) deferCnt <= deferCnt + 1'b1;
    end
  end

endmodule

// File: rtl/qsram_refresh_controller.sv
// Arbitrates one read/write port against periodic refresh and sequences
// the array edge strobes, row address and data paths.
`timescale 1ns/1ps
module qsram_refresh_controller
  import qsram_ctrl_pkg::*;
#(
  parameter int ROWS             = 16,
  parameter int ADDR_W           = $clog2(ROWS),
  parameter int DATA_W           = 8,
  parameter int PULSE_W          = 2,
  parameter int REFRESH_INTERVAL = 64,
  parameter int MAX_DEFER        = 4
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [ADDR_W-1:0] ReqAddr,
  input  logic [DATA_W-1:0] ReqData,
  output logic              RdValid,
  output logic [DATA_W-1:0] RdData,
  output logic [ADDR_W-1:0] RowAddr,
  output logic              ReadEdge,
  output logic              WriteEdge,
  output logic              RefreshEdge,
  output logic [DATA_W-1:0] ArrayInData,
  input  logic [DATA_W-1:0] ArrayOutData,
  output logic              RefreshOverrun
);

  localparam int PW_W = (PULSE_W > 1) ? $clog2(PULSE_W) : 1;
  localparam logic [PW_W-1:0] LAST_PULSE = PW_W'(PULSE_W - 1);

  qsram_state_t      state;
  strobe_sel_t       strobeSel;
  logic [PW_W-1:0]   pulseCnt;
  logic              pending;
  logic              deferSaturated;
  logic              accept;
  logic              lastPulse;
  logic              refreshStart;
  logic              refreshDone;
  logic [ADDR_W-1:0] refPtr;

  assign ReqReady     = (state == IDLE) && !(pending && deferSaturated);
  assign accept       = ReqValid && ReqReady;
  assign lastPulse    = (pulseCnt == LAST_PULSE);
  assign refreshStart = (state == IDLE) && !accept && pending;
  assign refreshDone  = (state == REFRESH) && lastPulse;
  assign {ReadEdge, WriteEdge, RefreshEdge} = strobeDecode(strobeSel);

  qsram_refresh_timer #(
    .ROWS             (ROWS),
    .ADDR_W           (ADDR_W),
    .REFRESH_INTERVAL (REFRESH_INTERVAL),
    .MAX_DEFER        (MAX_DEFER)
  ) timer (
    .Clock          (Clock),
    .Reset          (Reset),
    .RefreshStart   (refreshStart),
    .RefreshDone    (refreshDone),
    .AccessAccepted (accept),
    .Pending        (pending),
    .DeferSaturated (deferSaturated),
    .RefPtr         (refPtr),
    .RefreshOverrun (RefreshOverrun)
  );

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state       <= IDLE;
      strobeSel   <= STROBE_NONE;
      pulseCnt    <= '0;
      RowAddr     <= '0;
      ArrayInData <= '0;
      RdValid     <= 1'b0;
      RdData      <= '0;
    end else begin
      RdValid <= 1'b0;
      case (state)
        IDLE: begin
          pulseCnt <= '0;
          if (accept) begin
            RowAddr <= ReqAddr;
            if (ReqWrite) begin
              state       <= WRITE;
              strobeSel   <= STROBE_WRITE;
              ArrayInData <= ReqData;
            end else begin
              state     <= READ;
              strobeSel <= STROBE_READ;
            end
          end else if (pending) begin
            state     <= REFRESH;
            strobeSel <= STROBE_REFRESH;
            RowAddr   <= refPtr;
          end
        end
        WRITE, READ, REFRESH: begin
          if (lastPulse) begin
            state       <= RECOVER;
            strobeSel   <= STROBE_NONE;
            ArrayInData <= '0;
            // Cells are sampled while ReadEdge is still high.
            if (state == READ) begin
              RdData  <= ArrayOutData;
              RdValid <= 1'b1;
            end
          end else begin
            pulseCnt <= pulseCnt + 1'b1;
          end
        end
        RECOVER: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qsram_refresh_controller.sv
// Self-checking bench: table-driven accesses with a read scoreboard, plus
// refresh sweep, forced refresh, overrun and reset-mid-read sequences.
`timescale 1ns/1ps
module tb_qsram_refresh_controller;

  logic       Clock = 1'b0;
  always #5 Clock = ~Clock;

  // DUT A: default parameters
  logic       Reset = 1'b1, ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [3:0] ReqAddr = '0;
  logic [7:0] ReqData = '0, ArrayOutData = '0;
  logic       ReqReady, RdValid, ReadEdge, WriteEdge, RefreshEdge, RefreshOverrun;
  logic [7:0] RdData, ArrayInData;
  logic [3:0] RowAddr;

  // DUT B: MAX_DEFER = 255 for the overrun case
  logic       bReset = 1'b1, bReqValid = 1'b0;
  logic       bReqReady, bRdValid, bReadEdge, bWriteEdge, bRefreshEdge, bRefreshOverrun;
  logic [7:0] bRdData, bArrayInData;
  logic [3:0] bRowAddr;

  qsram_refresh_controller dutA (
    .Clock(Clock), .Reset(Reset), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqData(ReqData),
    .RdValid(RdValid), .RdData(RdData), .RowAddr(RowAddr),
    .ReadEdge(ReadEdge), .WriteEdge(WriteEdge), .RefreshEdge(RefreshEdge),
    .ArrayInData(ArrayInData), .ArrayOutData(ArrayOutData),
    .RefreshOverrun(RefreshOverrun)
  );

  qsram_refresh_controller #(.MAX_DEFER(255)) dutB (
    .Clock(Clock), .Reset(bReset), .ReqValid(bReqValid), .ReqReady(bReqReady),
    .ReqWrite(1'b0), .ReqAddr(4'd0), .ReqData(8'd0),
    .RdValid(bRdValid), .RdData(bRdData), .RowAddr(bRowAddr),
    .ReadEdge(bReadEdge), .WriteEdge(bWriteEdge), .RefreshEdge(bRefreshEdge),
    .ArrayInData(bArrayInData), .ArrayOutData(8'h00),
    .RefreshOverrun(bRefreshOverrun)
  );

  typedef struct {
    logic       wr;
    logic [3:0] addr;
    logic [7:0] data;
    logic [7:0] arrOut;
    logic [3:0] expRow;
    logic [7:0] expIn;
    logic [7:0] expRd;
  } vec_t;

  vec_t       vecs[8];
  logic [7:0] rdQ[$];
  logic [7:0] lastRd;
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge Clock);
    cyc++;
  endtask

  // Read scoreboard and strobe exclusivity monitor for DUT A
  always @(negedge Clock) begin
    logic [7:0] exp;
    if (RdValid === 1'b1) begin
      if (rdQ.size() == 0) begin
        check("rd_unexpected", 32'(RdValid), 32'd0);
      end else begin
        exp = rdQ.pop_front();
        check("rd_data", 32'(RdData), 32'(exp));
        $display("[TB] read response %02h expected %02h", RdData, exp);
      end
    end
    if ($countones({ReadEdge, WriteEdge, RefreshEdge}) > 1)
      check("strobe_onehot", 32'($countones({ReadEdge, WriteEdge, RefreshEdge})), 32'd1);
  end

  task automatic resetA();
    ReqValid = 1'b0;
    Reset    = 1'b1;
    tick();
    tick();
    check("rst_strobes", 32'({ReadEdge, WriteEdge, RefreshEdge}), 32'd0);
    check("rst_rowaddr", 32'(RowAddr), 32'd0);
    check("rst_indata",  32'(ArrayInData), 32'd0);
    check("rst_rdvalid", 32'(RdValid), 32'd0);
    check("rst_rddata",  32'(RdData), 32'd0);
    check("rst_overrun", 32'(RefreshOverrun), 32'd0);
    check("rst_ready",   32'(ReqReady), 32'd1);
    Reset  = 1'b0;
    lastRd = 8'h00;
    cyc    = 0;
  endtask

  task automatic doAccess(input vec_t v);
    int n = 0;
    while (!ReqReady && n < 50) begin
      tick();
      n++;
    end
    if (!ReqReady) begin
      check("ready_timeout", 32'(ReqReady), 32'd1);
      return;
    end
    ReqValid     = 1'b1;
    ReqWrite     = v.wr;
    ReqAddr      = v.addr;
    ReqData      = v.data;
    ArrayOutData = v.arrOut;
    if (!v.wr) rdQ.push_back(v.expRd);
    $display("[TB] cycle %0d %s addr %0h data %02h", cyc, v.wr ? "write" : "read", v.addr, v.data);
    tick();
    ReqValid = 1'b0;
    for (int p = 1; p <= 2; p++) begin
      check("strobe_kind", 32'({ReadEdge, WriteEdge, RefreshEdge}), v.wr ? 32'd2 : 32'd4);
      check("row_addr",    32'(RowAddr), 32'(v.expRow));
      check("in_data",     32'(ArrayInData), 32'(v.expIn));
      tick();
    end
    check("recover_strobes", 32'({ReadEdge, WriteEdge, RefreshEdge}), 32'd0);
    check("recover_ready",   32'(ReqReady), 32'd0);
    check("recover_rdvalid", 32'(RdValid), v.wr ? 32'd0 : 32'd1);
    check("recover_indata",  32'(ArrayInData), 32'd0);
    if (!v.wr) lastRd = v.expRd;
    tick();
    check("idle_ready",   32'(ReqReady), 32'd1);
    check("idle_rdvalid", 32'(RdValid), 32'd0);
    check("rd_hold",      32'(RdData), 32'(lastRd));
  endtask

  initial begin
    int firstRef, deferred, resumed, k, phase, n;
    logic prevReady;

    vecs[0] = '{1'b1, 4'h5, 8'hA5, 8'h00, 4'h5, 8'hA5, 8'h00};
    vecs[1] = '{1'b0, 4'h5, 8'h00, 8'h3C, 4'h5, 8'h00, 8'h3C};
    vecs[2] = '{1'b1, 4'h0, 8'hFF, 8'h11, 4'h0, 8'hFF, 8'h00};
    vecs[3] = '{1'b0, 4'hF, 8'h77, 8'h81, 4'hF, 8'h00, 8'h81};
    vecs[4] = '{1'b1, 4'hF, 8'h5A, 8'h00, 4'hF, 8'h5A, 8'h00};
    vecs[5] = '{1'b0, 4'h0, 8'h00, 8'h00, 4'h0, 8'h00, 8'h00};
    vecs[6] = '{1'b0, 4'h9, 8'h00, 8'hC3, 4'h9, 8'h00, 8'hC3};
    vecs[7] = '{1'b1, 4'h9, 8'h01, 8'hFF, 4'h9, 8'h01, 8'h00};

    // Write accepted at cycle 10, then the rest of the table
    resetA();
    while (cyc < 10) tick();
    for (int i = 0; i < 8; i++) doAccess(vecs[i]);

    // Idle refresh sweep through a full wrap of the row pointer
    resetA();
    while (cyc < 64 * 16 + 68) begin
      tick();
      k     = (cyc - 65) / 64;
      phase = (cyc - 65) % 64;
      if (cyc >= 65 && phase < 2) begin
        check("idle_ref_edge", 32'(RefreshEdge), 32'd1);
        check("idle_ref_row",  32'(RowAddr), 32'(k % 16));
      end else begin
        check("idle_ref_edge", 32'(RefreshEdge), 32'd0);
      end
    end
    check("idle_overrun", 32'(RefreshOverrun), 32'd0);

    // Forced refresh after MAX_DEFER deferred accesses
    resetA();
    while (cyc < 50) tick();
    ReqWrite = 1'b0;
    ReqAddr = 4'h3;
    ArrayOutData = 8'h5A;
    firstRef = -1;
    deferred = 0;
    resumed = 0;
    prevReady = 1'b1;
    while (cyc < 130) begin
      if (RefreshEdge && firstRef < 0) begin
        firstRef = cyc;
        check("forced_ready_low", 32'(prevReady), 32'd0);
      end
      ReqValid = (cyc < 120);
      if (ReqValid && ReqReady) begin
        rdQ.push_back(8'h5A);
        if (firstRef < 0 && cyc >= 64) deferred++;
        if (firstRef >= 0) resumed++;
      end
      prevReady = ReqReady;
      tick();
    end
    $display("[TB] forced refresh at cycle %0d after %0d deferred accesses", firstRef, deferred);
    check("forced_seen",     32'(firstRef >= 0), 32'd1);
    check("forced_deferred", 32'(deferred), 32'd4);
    check("forced_resumed",  32'(resumed > 0), 32'd1);
    check("sb_drain",        32'(rdQ.size()), 32'd0);

    // Reset during the first ReadEdge cycle
    resetA();
    while (cyc < 20) tick();
    ReqWrite = 1'b0;
    ReqAddr = 4'h7;
    ArrayOutData = 8'h99;
    check("rstrd_ready", 32'(ReqReady), 32'd1);
    ReqValid = 1'b1;
    tick();
    ReqValid = 1'b0;
    check("rstrd_edge", 32'(ReadEdge), 32'd1);
    Reset = 1'b1;
    tick();
    check("rstrd_strobes", 32'({ReadEdge, WriteEdge, RefreshEdge}), 32'd0);
    check("rstrd_rdvalid", 32'(RdValid), 32'd0);
    Reset = 1'b0;
    cyc = 0;
    tick();
    check("rstrd_no_rd", 32'(RdValid), 32'd0);
    while (cyc < 66) begin
      tick();
      check("rstrd_timer", 32'(RefreshEdge), (cyc >= 65) ? 32'd1 : 32'd0);
    end
    check("rstrd_row", 32'(RowAddr), 32'd0);

    // Overrun on DUT B with continuous requests
    bReset = 1'b1;
    tick();
    tick();
    check("b_rst_overrun", 32'(bRefreshOverrun), 32'd0);
    bReset = 1'b0;
    bReqValid = 1'b1;
    cyc = 0;
    while (cyc < 400) begin
      tick();
      if (cyc == 127) check("b_overrun_early", 32'(bRefreshOverrun), 32'd0);
      if (cyc == 128) check("b_overrun_set",   32'(bRefreshOverrun), 32'd1);
    end
    check("b_overrun_sticky", 32'(bRefreshOverrun), 32'd1);
    bReqValid = 1'b0;
    bReset = 1'b1;
    n = 0;
    tick();
    check("b_overrun_clear", 32'(bRefreshOverrun), 32'd0);
    check("b_rst_ready",     32'(bReqReady), 32'd1);
    check("b_rst_strobes",   32'({bReadEdge, bWriteEdge, bRefreshEdge}), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog");
  end

endmodule
